// File: rtl/csi_2_packet_decoder.sv
// CSI-2 low-level packet decoder: splits PPI HS byte bursts into header, payload and footer.
// Optional payload CRC-16 check is compiled in with `define CSI2_CRC_CHECK_EN.
module csi_2_packet_decoder (
    input  logic        RxByteClkHS,
    input  logic        ResetN,
    input  logic [7:0]  RxDataHS,
    input  logic        RxValidHS,
    input  logic        RxSyncHS,
    input  logic        RxActiveHS,
    output logic [1:0]  PktVC,
    output logic [5:0]  PktDataType,
    output logic [15:0] PktWordCount,
    output logic        PktHdrValid,
    output logic        ShortPktValid,
    output logic [7:0]  PayloadData,
    output logic        PayloadValid,
    output logic        PayloadLast,
    output logic        PktEnd,
    output logic        ErrEcc,
    output logic        ErrCrc,
    output logic        ErrTrunc
);

    localparam int unsigned WC_W  = 16;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_FOOTER,
        S_WAIT_EOT
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        di_q, di_d;
    logic [7:0]        wc_lo_q, wc_lo_d;
    logic [7:0]        wc_hi_q, wc_hi_d;
    logic [WC_W-1:0]   cnt_q, cnt_d;
    logic [1:0]        vc_q, vc_d;
    logic [5:0]        dt_q, dt_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic              hdr_valid_q, hdr_valid_d;
    logic              short_valid_q, short_valid_d;
    logic [7:0]        pay_data_q, pay_data_d;
    logic              pay_valid_q, pay_valid_d;
    logic              pay_last_q, pay_last_d;
    logic              pkt_end_q, pkt_end_d;
    logic              err_ecc_q, err_ecc_d;
    logic              err_trunc_q, err_trunc_d;
    logic [5:0]        ecc_calc;

    // CSI-2 header Hamming parity, D0 = DI bit 0, D23 = WC high bit 7
    function automatic logic [5:0] ecc6(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    assign ecc_calc = ecc6({wc_hi_q, wc_lo_q, di_q});

`ifdef CSI2_CRC_CHECK_EN
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc_lo_q, crc_lo_d;
    logic        err_crc_q, err_crc_d;

    // Reflected CRC-16 (0x8408), one byte LSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction
`endif

    always_ff @(posedge RxByteClkHS or negedge ResetN) begin
        if (!ResetN) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            di_q          <= '0;
            wc_lo_q       <= '0;
            wc_hi_q       <= '0;
            cnt_q         <= '0;
            vc_q          <= '0;
            dt_q          <= '0;
            wc_q          <= '0;
            hdr_valid_q   <= 1'b0;
            short_valid_q <= 1'b0;
            pay_data_q    <= '0;
            pay_valid_q   <= 1'b0;
            pay_last_q    <= 1'b0;
            pkt_end_q     <= 1'b0;
            err_ecc_q     <= 1'b0;
            err_trunc_q   <= 1'b0;
`ifdef CSI2_CRC_CHECK_EN
            crc_q         <= 16'hFFFF;
            crc_lo_q      <= '0;
            err_crc_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            di_q          <= di_d;
            wc_lo_q       <= wc_lo_d;
            wc_hi_q       <= wc_hi_d;
            cnt_q         <= cnt_d;
            vc_q          <= vc_d;
            dt_q          <= dt_d;
            wc_q          <= wc_d;
            hdr_valid_q   <= hdr_valid_d;
            short_valid_q <= short_valid_d;
            pay_data_q    <= pay_data_d;
            pay_valid_q   <= pay_valid_d;
            pay_last_q    <= pay_last_d;
            pkt_end_q     <= pkt_end_d;
            err_ecc_q     <= err_ecc_d;
            err_trunc_q   <= err_trunc_d;
`ifdef CSI2_CRC_CHECK_EN
            crc_q         <= crc_d;
            crc_lo_q      <= crc_lo_d;
            err_crc_q     <= err_crc_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        di_d          = di_q;
        wc_lo_d       = wc_lo_q;
        wc_hi_d       = wc_hi_q;
        cnt_d         = cnt_q;
        vc_d          = vc_q;
        dt_d          = dt_q;
        wc_d          = wc_q;
        hdr_valid_d   = 1'b0;
        short_valid_d = 1'b0;
        pay_data_d    = pay_data_q;
        pay_valid_d   = 1'b0;
        pay_last_d    = 1'b0;
        pkt_end_d     = 1'b0;
        err_ecc_d     = 1'b0;
        err_trunc_d   = 1'b0;
`ifdef CSI2_CRC_CHECK_EN
        crc_d         = crc_q;
        crc_lo_d      = crc_lo_q;
        err_crc_d     = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (RxValidHS && RxSyncHS) begin
                    di_d    = RxDataHS;
                    idx_d   = IDX_W'(1);
                    state_d = S_HDR;
                end
            end
            S_WAIT_EOT: begin
                if (!RxActiveHS) begin
                    state_d = S_IDLE;
                end
            end
            S_HDR, S_PAYLOAD, S_FOOTER: begin
                if (!RxActiveHS) begin
                    err_trunc_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (RxValidHS && RxSyncHS) begin
                    // Unexpected sync: abandon the packet and restart on this DI
                    err_trunc_d = 1'b1;
                    di_d        = RxDataHS;
                    idx_d       = IDX_W'(1);
                    state_d     = S_HDR;
                end else if (RxValidHS) begin
                    if (state_q == S_HDR) begin
                        if (idx_q == IDX_W'(1)) begin
                            wc_lo_d = RxDataHS;
                            idx_d   = IDX_W'(2);
                        end else if (idx_q == IDX_W'(2)) begin
                            wc_hi_d = RxDataHS;
                            idx_d   = IDX_W'(3);
                        end else if (RxDataHS[5:0] != ecc_calc) begin
                            err_ecc_d = 1'b1;
                            state_d   = S_WAIT_EOT;
                        end else begin
                            vc_d  = di_q[7:6];
                            dt_d  = di_q[5:0];
                            wc_d  = {wc_hi_q, wc_lo_q};
                            idx_d = '0;
`ifdef CSI2_CRC_CHECK_EN
                            crc_d = 16'hFFFF;
`endif
                            if (di_q[5:0] <= 6'h0F) begin
                                short_valid_d = 1'b1;
                                state_d       = S_WAIT_EOT;
                            end else begin
                                hdr_valid_d = 1'b1;
                                cnt_d       = {wc_hi_q, wc_lo_q};
                                state_d     = ({wc_hi_q, wc_lo_q} == '0) ? S_FOOTER : S_PAYLOAD;
                            end
                        end
                    end else if (state_q == S_PAYLOAD) begin
                        pay_data_d  = RxDataHS;
                        pay_valid_d = 1'b1;
                        cnt_d       = cnt_q - WC_W'(1);
`ifdef CSI2_CRC_CHECK_EN
                        crc_d       = crc16_byte(crc_q, RxDataHS);
`endif
                        if (cnt_q == WC_W'(1)) begin
                            pay_last_d = 1'b1;
                            idx_d      = '0;
                            state_d    = S_FOOTER;
                        end
                    end else begin
                        if (idx_q == '0) begin
`ifdef CSI2_CRC_CHECK_EN
                            crc_lo_d = RxDataHS;
`endif
                            idx_d = IDX_W'(1);
                        end else begin
                            pkt_end_d = 1'b1;
`ifdef CSI2_CRC_CHECK_EN
                            err_crc_d = ({RxDataHS, crc_lo_q} != crc_q);
`endif
                            state_d   = S_WAIT_EOT;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign PktVC         = vc_q;
    assign PktDataType   = dt_q;
    assign PktWordCount  = wc_q;
    assign PktHdrValid   = hdr_valid_q;
    assign ShortPktValid = short_valid_q;
    assign PayloadData   = pay_data_q;
    assign PayloadValid  = pay_valid_q;
    assign PayloadLast   = pay_last_q;
    assign PktEnd        = pkt_end_q;
    assign ErrEcc        = err_ecc_q;
    assign ErrTrunc      = err_trunc_q;
`ifdef CSI2_CRC_CHECK_EN
    assign ErrCrc        = err_crc_q;
`else
    assign ErrCrc        = 1'b0;
`endif

endmodule

// File: tb/tb_csi_2_packet_decoder.sv
// Directed bench for csi_2_packet_decoder: short/long packets, stalls, ECC, truncation, CRC, reset.
module tb_csi_2_packet_decoder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  RxDataHS;
    logic        RxValidHS;
    logic        RxSyncHS;
    logic        RxActiveHS;
    logic [1:0]  PktVC;
    logic [5:0]  PktDataType;
    logic [15:0] PktWordCount;
    logic        PktHdrValid;
    logic        ShortPktValid;
    logic [7:0]  PayloadData;
    logic        PayloadValid;
    logic        PayloadLast;
    logic        PktEnd;
    logic        ErrEcc;
    logic        ErrCrc;
    logic        ErrTrunc;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

`ifdef CSI2_CRC_CHECK_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    csi_2_packet_decoder dut (
        .RxByteClkHS  (clk),
        .ResetN       (rst_n),
        .RxDataHS     (RxDataHS),
        .RxValidHS    (RxValidHS),
        .RxSyncHS     (RxSyncHS),
        .RxActiveHS   (RxActiveHS),
        .PktVC        (PktVC),
        .PktDataType  (PktDataType),
        .PktWordCount (PktWordCount),
        .PktHdrValid  (PktHdrValid),
        .ShortPktValid(ShortPktValid),
        .PayloadData  (PayloadData),
        .PayloadValid (PayloadValid),
        .PayloadLast  (PayloadLast),
        .PktEnd       (PktEnd),
        .ErrEcc       (ErrEcc),
        .ErrCrc       (ErrCrc),
        .ErrTrunc     (ErrTrunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given PPI inputs; outputs sampled 1ns after the edge
    task automatic step(input logic v, input logic s, input logic a, input logic [7:0] d);
        @(negedge clk);
        RxValidHS  = v;
        RxSyncHS   = s;
        RxActiveHS = a;
        RxDataHS   = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] crc_ref(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        logic [15:0] c;
        logic [7:0]  bytes [4];
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        c = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            c = c ^ {8'h00, bytes[k]};
            for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_hdrv"}, 32'(PktHdrValid), 32'h0);
        chk({tag, "_pv"},   32'(PayloadValid), 32'h0);
        chk({tag, "_end"},  32'(PktEnd), 32'h0);
        chk({tag, "_trunc"}, 32'(ErrTrunc), 32'h0);
    endtask

    // Header 2A/0004/33, payload 11 22 33 44, footer CRC (optionally corrupted), then EoT
    task automatic send_long(input logic gaps, input logic corrupt, input string tag);
        logic [7:0]  pay [4];
        logic [15:0] crc;
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        crc = crc_ref(8'h11, 8'h22, 8'h33, 8'h44);
        step(1, 1, 1, 8'h2A);
        step(1, 0, 1, 8'h04);
        if (gaps) step(0, 0, 1, 8'hEE);
        step(1, 0, 1, 8'h00);
        step(1, 0, 1, 8'h33);
        chk({tag, "_hdrv"}, 32'(PktHdrValid), 32'h1);
        chk({tag, "_vc"},   32'(PktVC), 32'h0);
        chk({tag, "_dt"},   32'(PktDataType), 32'h2A);
        chk({tag, "_wc"},   32'(PktWordCount), 32'h4);
        chk({tag, "_ecc"},  32'(ErrEcc), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, pay[i]);
            chk({tag, "_pv"},   32'(PayloadValid), 32'h1);
            chk({tag, "_pd"},   32'(PayloadData), 32'(pay[i]));
            chk({tag, "_last"}, 32'(PayloadLast), (i == 3) ? 32'h1 : 32'h0);
            if (gaps) begin
                step(0, 0, 1, 8'hEE);
                chk({tag, "_gap_pv"}, 32'(PayloadValid), 32'h0);
            end
        end
        step(1, 0, 1, crc[7:0]);
        chk({tag, "_f0_end"}, 32'(PktEnd), 32'h0);
        chk({tag, "_f0_pv"},  32'(PayloadValid), 32'h0);
        step(1, 0, 1, corrupt ? (crc[15:8] ^ 8'h01) : crc[15:8]);
        chk({tag, "_end"}, 32'(PktEnd), 32'h1);
        chk({tag, "_crc"}, 32'(ErrCrc), 32'(corrupt & CRC_ON));
        step(1, 0, 1, 8'h55);
        chk({tag, "_eot_pv"}, 32'(PayloadValid), 32'h0);
        step(0, 0, 0, 8'h00);
        chk({tag, "_eot_trunc"}, 32'(ErrTrunc), 32'h0);
    endtask

    initial begin
        RxDataHS = '0; RxValidHS = 1'b0; RxSyncHS = 1'b0; RxActiveHS = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dt",  32'(PktDataType), 32'h0);
        chk("rst_wc",  32'(PktWordCount), 32'h0);
        chk("rst_spv", 32'(ShortPktValid), 32'h0);
        chk("rst_ecc", 32'(ErrEcc), 32'h0);
        chk("rst_crc", 32'(ErrCrc), 32'h0);
        chk_idle_outs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Bytes without sync in IDLE are ignored
        step(1, 0, 1, 8'h2A);
        step(1, 0, 1, 8'h33);
        chk_idle_outs("nosync");

        // Short packet
        step(1, 1, 1, 8'h00);
        step(1, 0, 1, 8'h01);
        step(1, 0, 1, 8'h00);
        step(1, 0, 1, 8'h1A);
        chk("sp_valid", 32'(ShortPktValid), 32'h1);
        chk("sp_dt",    32'(PktDataType), 32'h00);
        chk("sp_wc",    32'(PktWordCount), 32'h0001);
        chk("sp_ecc",   32'(ErrEcc), 32'h0);
        chk("sp_hdrv",  32'(PktHdrValid), 32'h0);
        step(0, 0, 0, 8'h00);
        chk("sp_eot_trunc", 32'(ErrTrunc), 32'h0);
        chk("sp_pulse",     32'(ShortPktValid), 32'h0);

        // Long packet, back-to-back and with stalls
        send_long(1'b0, 1'b0, "lp");
        send_long(1'b1, 1'b0, "lpg");

        // ECC mismatch
        step(1, 1, 1, 8'h2A);
        step(1, 0, 1, 8'h04);
        step(1, 0, 1, 8'h00);
        step(1, 0, 1, 8'h32);
        chk("ecc_err",  32'(ErrEcc), 32'h1);
        chk("ecc_hdrv", 32'(PktHdrValid), 32'h0);
        step(1, 0, 1, 8'h11);
        chk("ecc_pv", 32'(PayloadValid), 32'h0);
        step(0, 0, 0, 8'h00);
        chk("ecc_eot_trunc", 32'(ErrTrunc), 32'h0);
        step(1, 0, 1, 8'h11);
        chk("ecc_idle_pv", 32'(PayloadValid), 32'h0);
        step(0, 0, 0, 8'h00);

        // Truncation by RxActiveHS low after 2 payload bytes
        step(1, 1, 1, 8'h2A);
        step(1, 0, 1, 8'h04);
        step(1, 0, 1, 8'h00);
        step(1, 0, 1, 8'h33);
        step(1, 0, 1, 8'h11);
        step(1, 0, 1, 8'h22);
        chk("tr_last_b2", 32'(PayloadLast), 32'h0);
        step(0, 0, 0, 8'h00);
        chk("tr_err",  32'(ErrTrunc), 32'h1);
        chk("tr_last", 32'(PayloadLast), 32'h0);
        chk("tr_end",  32'(PktEnd), 32'h0);
        step(0, 0, 0, 8'h00);
        chk("tr_pulse", 32'(ErrTrunc), 32'h0);
        send_long(1'b0, 1'b0, "tr_next");

        // Re-sync mid-payload: new DI restarts header decode
        step(1, 1, 1, 8'h2A);
        step(1, 0, 1, 8'h04);
        step(1, 0, 1, 8'h00);
        step(1, 0, 1, 8'h33);
        step(1, 0, 1, 8'h11);
        step(1, 1, 1, 8'h00);
        chk("rs_err", 32'(ErrTrunc), 32'h1);
        chk("rs_pv",  32'(PayloadValid), 32'h0);
        step(1, 0, 1, 8'h01);
        step(1, 0, 1, 8'h00);
        step(1, 0, 1, 8'h1A);
        chk("rs_sp", 32'(ShortPktValid), 32'h1);
        chk("rs_wc", 32'(PktWordCount), 32'h0001);
        step(0, 0, 0, 8'h00);

        // Corrupted CRC high byte
        send_long(1'b0, 1'b1, "crc");

        // Zero word count: header straight to footer, empty-payload CRC is 0xFFFF
        step(1, 1, 1, 8'h2A);
        step(1, 0, 1, 8'h00);
        step(1, 0, 1, 8'h00);
        step(1, 0, 1, 8'h10);
        chk("wc0_hdrv", 32'(PktHdrValid), 32'h1);
        chk("wc0_wc",   32'(PktWordCount), 32'h0);
        chk("wc0_ecc",  32'(ErrEcc), 32'h0);
        step(1, 0, 1, 8'hFF);
        chk("wc0_pv",   32'(PayloadValid), 32'h0);
        step(1, 0, 1, 8'hFF);
        chk("wc0_end",  32'(PktEnd), 32'h1);
        chk("wc0_crc",  32'(ErrCrc), 32'h0);
        chk("wc0_pv2",  32'(PayloadValid), 32'h0);
        step(0, 0, 0, 8'h00);

        // Async reset in the middle of a header
        step(1, 1, 1, 8'h00);
        step(1, 0, 1, 8'h04);
        chk("ar_dt_before", 32'(PktDataType), 32'h2A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_dt",   32'(PktDataType), 32'h0);
        chk("ar_wc",   32'(PktWordCount), 32'h0);
        chk("ar_data", 32'(PayloadData), 32'h0);
        chk_idle_outs("ar");
        step(1, 0, 1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 1, 8'h00);
        chk("ar_rel_trunc", 32'(ErrTrunc), 32'h0);
        step(0, 0, 0, 8'h00);
        chk("ar_rel_trunc2", 32'(ErrTrunc), 32'h0);
        step(1, 1, 1, 8'h00);
        step(1, 0, 1, 8'h01);
        step(1, 0, 1, 8'h00);
        step(1, 0, 1, 8'h1A);
        chk("ar_sp", 32'(ShortPktValid), 32'h1);
        step(0, 0, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
